// File: rtl/ebi_msg_receiver.sv
// ebi_msg_receiver: off-die framed message receiver with parity check, credit return and delivery FIFO
module ebi_msg_receiver #(
  parameter int MSG_LEN    = 64,
  parameter int VC_W       = 3,
  parameter int OFF_DIE_WD = 16,
  parameter int PARITY_LEN = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  rx_start,
  input  logic [OFF_DIE_WD-1:0] rx_data,
  input  logic                  rx_end,
  output logic                  cr_start,
  output logic [1:0]            cr_code,
  output logic                  msg_valid,
  input  logic                  msg_ready,
  output logic [MSG_LEN-1:0]    msg_data,
  output logic [VC_W-1:0]       msg_vc
);
  localparam int NFLIT = (MSG_LEN + OFF_DIE_WD - 1) / OFF_DIE_WD;
  localparam int CW    = NFLIT > 1 ? $clog2(NFLIT) : 1;
  localparam int AW    = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int EW    = VC_W + MSG_LEN;
  typedef enum logic [2:0] {RECV_IDLE, RECV_MESSAGE, RECV_PARITY, RECV_END, MAKE_CREDIT} recv_t;
  typedef enum logic [1:0] {SCREDIT_IDLE, SCREDIT_START_BIT, SCREDIT_VALUE_SEND} cred_t;
  recv_t                 r_rstate;
  cred_t                 r_cstate;
  logic [CW-1:0]         r_cnt;
  logic [VC_W-1:0]       r_vc;
  logic [MSG_LEN-1:0]    r_msg;
  logic [PARITY_LEN-1:0] r_par;
  logic                  r_end;
  logic                  r_ok;
  logic [EW-1:0]         r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wp;
  logic [AW-1:0]         r_rp;
  logic [AW:0]           r_count;
  logic [PARITY_LEN-1:0] w_par_exp;
  logic                  w_full;
  logic                  w_good;
  logic                  w_push;
  logic                  w_pop;

  // expected parity: bit i folds every message bit whose index is i mod PARITY_LEN
  always_comb begin
    w_par_exp = '0;
    for (int j = 0; j < MSG_LEN; j++) w_par_exp[j % PARITY_LEN] ^= r_msg[j];
  end

  // fullness is judged before any same-cycle pop, so a full FIFO always rejects
  assign w_full    = r_count == (AW+1)'(FIFO_DEPTH);
  assign w_good    = (w_par_exp == r_par) && r_end && !w_full;
  assign w_push    = (r_rstate == MAKE_CREDIT) && w_good;
  assign w_pop     = msg_valid && msg_ready;
  assign msg_valid = r_count != '0;
  assign {msg_vc, msg_data} = msg_valid ? r_mem[r_rp] : '0;

  // receive FSM: start, NFLIT data flits, parity, end, then one classification cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rstate <= RECV_IDLE;
      r_cnt    <= '0;
      r_vc     <= '0;
      r_msg    <= '0;
      r_par    <= '0;
      r_end    <= 1'b0;
    end else begin
      for (int j = 0; j < MSG_LEN; j++)
        if (r_rstate == RECV_MESSAGE && int'(r_cnt) == j / OFF_DIE_WD) r_msg[j] <= rx_data[j % OFF_DIE_WD];
      case (r_rstate)
        RECV_IDLE: if (rx_start) begin
          r_vc     <= rx_data[VC_W-1:0];
          r_cnt    <= '0;
          r_rstate <= RECV_MESSAGE;
        end
        RECV_MESSAGE: begin
          r_cnt    <= r_cnt == CW'(NFLIT-1) ? '0 : r_cnt + CW'(1);
          r_rstate <= r_cnt == CW'(NFLIT-1) ? RECV_PARITY : RECV_MESSAGE;
        end
        RECV_PARITY: begin
          r_par    <= rx_data[PARITY_LEN-1:0];
          r_rstate <= RECV_END;
        end
        RECV_END: begin
          r_end    <= rx_end;
          r_rstate <= MAKE_CREDIT;
        end
        default: r_rstate <= RECV_IDLE;
      endcase
    end
  end

  // credit FSM: start bit one cycle after classification, code the cycle after that
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cstate <= SCREDIT_IDLE;
      r_ok     <= 1'b0;
      cr_start <= 1'b0;
      cr_code  <= 2'b00;
    end else begin
      case (r_cstate)
        SCREDIT_IDLE: if (r_rstate == MAKE_CREDIT) begin
          r_ok     <= w_good;
          cr_start <= 1'b1;
          r_cstate <= SCREDIT_START_BIT;
        end
        SCREDIT_START_BIT: begin
          cr_start <= 1'b0;
          cr_code  <= r_ok ? 2'b01 : 2'b10;
          r_cstate <= SCREDIT_VALUE_SEND;
        end
        default: begin
          cr_code  <= 2'b00;
          r_cstate <= SCREDIT_IDLE;
        end
      endcase
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally for power-of-2 depth
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      r_wp    <= w_push ? r_wp + AW'(1) : r_wp;
      r_rp    <= w_pop ? r_rp + AW'(1) : r_rp;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  // FIFO storage; head output is masked while empty so stale entries never show
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= {r_vc, r_msg};
  end
endmodule

// File: tb/tb_ebi_msg_receiver.sv
// tb_ebi_msg_receiver: scoreboard bench for ebi_msg_receiver
module tb_ebi_msg_receiver;
  logic        clk = 0;
  logic        rstn = 0;
  logic        rx_start = 0;
  logic [15:0] rx_data = 0;
  logic        rx_end = 0;
  logic        msg_ready = 0;
  logic        cr_start;
  logic [1:0]  cr_code;
  logic        msg_valid;
  logic [63:0] msg_data;
  logic [2:0]  msg_vc;
  int          checks = 0;
  int          errors = 0;
  logic [66:0] exp_msg[$];
  logic [1:0]  exp_cr[$];
  logic        prev_start = 0;
  logic [66:0] want_msg;
  logic [1:0]  want_cr;

  ebi_msg_receiver dut (
    .clk(clk), .rstn(rstn), .rx_start(rx_start), .rx_data(rx_data), .rx_end(rx_end),
    .cr_start(cr_start), .cr_code(cr_code), .msg_valid(msg_valid), .msg_ready(msg_ready),
    .msg_data(msg_data), .msg_vc(msg_vc)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // delivered messages must match the scoreboard in arrival order
  always @(negedge clk) begin
    if (rstn && msg_valid && msg_ready) begin
      checks++;
      if (exp_msg.size() == 0) begin
        errors++;
        $display("FAIL msg_unexpected: got vc=%0d data=%h, none expected", msg_vc, msg_data);
      end else begin
        want_msg = exp_msg.pop_front();
        if ({msg_vc, msg_data} !== want_msg) begin
          errors++;
          $display("FAIL msg_data: got vc=%0d data=%h, want vc=%0d data=%h", msg_vc, msg_data, want_msg[66:64], want_msg[63:0]);
        end
      end
    end
  end

  // every credit code must follow a start bit and match the predicted verdict
  always @(negedge clk) begin
    if (rstn) begin
      if (cr_code !== 2'b00) begin
        checks++;
        if (exp_cr.size() == 0 || !prev_start) begin
          errors++;
          $display("FAIL cr_unexpected: got code=%b start_before=%b queued=%0d", cr_code, prev_start, exp_cr.size());
        end else begin
          want_cr = exp_cr.pop_front();
          if (cr_code !== want_cr) begin
            errors++;
            $display("FAIL cr_code: got %b, want %b", cr_code, want_cr);
          end
        end
      end
      prev_start = cr_start;
    end else prev_start = 0;
  end

  function automatic logic [7:0] calc_par(input logic [63:0] m);
    logic [7:0] p = 0;
    for (int j = 0; j < 64; j++) p[j % 8] ^= m[j];
    return p;
  endfunction

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // drives one frame and returns in E+2, where a new start may be driven
  task automatic send_frame(input logic [2:0] vc, input logic [63:0] msg, input logic [7:0] par,
                            input logic e, input logic spur);
    logic good;
    logic was_empty;
    rx_start = 1;
    rx_data  = 16'(vc);
    step();
    for (int k = 0; k < 4; k++) begin
      rx_start = spur && k == 1;
      rx_data  = msg[k*16 +: 16];
      step();
    end
    rx_start = 0;
    rx_data  = {8'h00, par};
    step();
    rx_data = 16'($urandom);
    rx_end  = e;
    step();
    rx_end    = 0;
    rx_data   = 0;
    was_empty = exp_msg.size() == 0;
    good      = par == calc_par(msg) && e && exp_msg.size() < 4;
    exp_cr.push_back(good ? 2'b01 : 2'b10);
    if (good) exp_msg.push_back({vc, msg});
    checks++;
    if (cr_start !== 1'b0) begin
      errors++;
      $display("FAIL cr_start_early: got %b at E+1, want 0", cr_start);
    end
    step();
    checks++;
    if (cr_start !== 1'b1) begin
      errors++;
      $display("FAIL cr_start_e2: got %b at E+2, want 1", cr_start);
    end
    if (was_empty) begin
      checks++;
      if (msg_valid !== good) begin
        errors++;
        $display("FAIL msg_valid_e2: got %b at E+2, want %b", msg_valid, good);
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if ({cr_start, cr_code, msg_valid, msg_data, msg_vc} !== 70'd0) begin
      errors++;
      $display("FAIL %s: got cr_start=%b cr_code=%b msg_valid=%b msg_data=%h msg_vc=%0d, want all 0",
               tag, cr_start, cr_code, msg_valid, msg_data, msg_vc);
    end
  endtask

  task automatic test_reset();
    step(2);
    check_idle_outputs("reset_outputs");
    rstn = 1;
    step(2);
    check_idle_outputs("post_reset_outputs");
  endtask

  task automatic test_good();
    msg_ready = 1;
    send_frame(3'd5, 64'h200, 8'h02, 1, 0);
    step(4);
  endtask

  task automatic test_parity_err();
    send_frame(3'd5, 64'h200, 8'h03, 1, 0);
    step(4);
  endtask

  task automatic test_no_end();
    send_frame(3'd5, 64'h200, 8'h02, 0, 0);
    step(4);
  endtask

  task automatic test_spurious();
    send_frame(3'd2, 64'hDEAD_BEEF_0123_4567, calc_par(64'hDEAD_BEEF_0123_4567), 1, 1);
    step(4);
  endtask

  task automatic test_back_to_back();
    logic [63:0] m;
    for (int i = 0; i < 8; i++) begin
      m = {$urandom, $urandom};
      send_frame(3'($urandom), m, (i % 3 == 2) ? calc_par(m) ^ 8'h10 : calc_par(m), i != 5, 0);
    end
    step(4);
  endtask

  task automatic test_fifo_full();
    logic [63:0] m;
    msg_ready = 0;
    for (int i = 0; i < 5; i++) begin
      m = {$urandom, $urandom};
      send_frame(3'(i + 1), m, calc_par(m), 1, 0);
    end
    step(4);
    checks++;
    if (msg_valid !== 1'b1 || exp_msg.size() != 4) begin
      errors++;
      $display("FAIL fifo_full_hold: got msg_valid=%b, want 1 with 4 queued (model has %0d)", msg_valid, exp_msg.size());
    end
    msg_ready = 1;
    step(6);
    checks++;
    if (msg_valid !== 1'b0 || exp_msg.size() != 0) begin
      errors++;
      $display("FAIL fifo_drain: got msg_valid=%b, model left %0d, want 0 and 0", msg_valid, exp_msg.size());
    end
  endtask

  task automatic test_reset_mid();
    msg_ready = 0;
    send_frame(3'd6, 64'h1234, calc_par(64'h1234), 1, 0);
    step(4);
    rx_start = 1;
    rx_data  = 16'd1;
    step();
    rx_start = 0;
    rx_data  = 16'hAAAA;
    step(2);
    rstn = 0;
    #1;
    check_idle_outputs("reset_mid_outputs");
    exp_msg.delete();
    step(2);
    check_idle_outputs("reset_mid_hold");
    rx_data   = 0;
    msg_ready = 1;
    rstn      = 1;
    send_frame(3'd7, 64'hFEED_0000_CAFE_0001, calc_par(64'hFEED_0000_CAFE_0001), 1, 0);
    step(6);
  endtask

  initial begin
    test_reset();
    test_good();
    test_parity_err();
    test_no_end();
    test_spurious();
    test_back_to_back();
    test_fifo_full();
    test_reset_mid();
    step(4);
    checks++;
    if (exp_cr.size() != 0 || exp_msg.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d credits and %0d messages outstanding, want 0 and 0", exp_cr.size(), exp_msg.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ebi_msg_receiver.md
EBI_MSG_RECEIVER -- requirements
Module: ebi_msg_receiver

Interface
REQ-001 SHALL have parameter MSG_LEN, default 64, message payload bits per frame.
REQ-002 SHALL have parameter VC_W, default 3, virtual-channel id width.
REQ-003 SHALL have parameter OFF_DIE_WD, default 16, off-die lane width in bits.
REQ-004 SHALL have parameter PARITY_LEN, default 8, parity field width.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, received-message buffer entries (power of 2).
REQ-006 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-007 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port rx_start, input, 1, frame start bit.
REQ-009 SHALL have port rx_data, input, OFF_DIE_WD, link data lanes.
REQ-010 SHALL have port rx_end, input, 1, frame end bit.
REQ-011 SHALL have port cr_start, output, 1, credit start bit.
REQ-012 SHALL have port cr_code, output, 2, credit value: 00 NO_CREDIT, 01 SUCCESS, 10 FAILURE.
REQ-013 SHALL have ports msg_valid (output, 1), msg_ready (input, 1), msg_data (output, MSG_LEN) and msg_vc (output, VC_W), forming the on-die delivery handshake.

Function
REQ-014 SHALL use NFLIT = ceil(MSG_LEN/OFF_DIE_WD) data cycles per frame; NFLIT = 4 at defaults.
REQ-015 SHALL receive a frame as contiguous cycles: start (rx_start=1, VC id on rx_data[VC_W-1:0]), then NFLIT data cycles (flit k = msg bits [k*OFF_DIE_WD +: OFF_DIE_WD]; last-flit padding ignored), then one parity cycle (rx_data[PARITY_LEN-1:0]), then one end cycle (rx_end expected 1).
REQ-016 SHALL implement receive FSM states RECV_IDLE, RECV_MESSAGE, RECV_PARITY, RECV_END, MAKE_CREDIT, advancing one state per cycle except RECV_MESSAGE, which holds for NFLIT cycles using a flit counter.
REQ-017 SHALL ignore rx_start in every state except RECV_IDLE; rx_data and rx_end are don't-care in RECV_IDLE.
REQ-018 SHALL compute expected parity bit i as the XOR of message bits j with j mod PARITY_LEN == i, over j < MSG_LEN only.
REQ-019 SHALL classify a frame in MAKE_CREDIT as good iff parity matches, rx_end was 1 in the end cycle, and the FIFO is not full.
REQ-020 SHALL push {vc, message} into the FIFO in the MAKE_CREDIT cycle for a good frame, and SHALL drop a bad frame.
REQ-021 SHALL implement credit FSM states SCREDIT_IDLE, SCREDIT_START_BIT and SCREDIT_VALUE_SEND, triggered from MAKE_CREDIT.
REQ-022 SHALL, with E the cycle in which the end bit is sampled, drive cr_start=1 only in cycle E+2 and the code (01 good / 10 bad) only in cycle E+3; cr_code SHALL be 00 in all other cycles; both outputs registered.
REQ-023 SHALL return the receive FSM to RECV_IDLE in cycle E+2, so that it can accept a new start from E+2.
REQ-024 SHALL drive msg_valid high whenever the FIFO is non-empty, with msg_data/msg_vc taken from the head entry; msg_valid SHALL not depend combinationally on msg_ready.
REQ-025 SHALL pop on msg_valid & msg_ready; a push to a non-empty FIFO becomes visible at the head only after the older entries; a write in E+1 first appears on msg_valid in E+2.
REQ-026 SHALL, on simultaneous push and pop with the FIFO full, count the frame as FAILURE, since fullness is evaluated before the pop.
REQ-027 SHALL wrap FIFO pointers modulo FIFO_DEPTH and SHALL track occupancy 0..FIFO_DEPTH without overflow.

Reset
REQ-028 SHALL, while rstn=0, hold both FSMs idle, the FIFO empty, the flit counter 0, and cr_start=0, cr_code=00, msg_valid=0, msg_data=0, msg_vc=0.
REQ-029 SHALL, on reset assertion mid-frame or mid-credit, discard the partial frame with no credit emitted after release; the first rx_start is accepted in the first cycle after rstn rises.

Verification
REQ-030 SHALL cover a good frame: vc=5, flits 0x0200,0,0,0, parity 0x02, rx_end=1 -> cr_start at E+2, cr_code=01 at E+3, msg_valid at E+2 with msg_data=64'h200, msg_vc=5.
REQ-031 SHALL cover a parity error: same frame with parity 0x03 -> cr_code=10 at E+3, msg_valid stays 0.
REQ-032 SHALL cover a missing end bit: good parity, rx_end=0 -> cr_code=10, frame dropped.
REQ-033 SHALL cover FIFO full: msg_ready=0, 5 good frames -> first 4 get 01, 5th gets 10; then msg_ready=1 drains 4 entries in arrival order.
REQ-034 SHALL cover a spurious start: rx_start=1 in a data cycle -> ignored, frame still completes normally.
REQ-035 SHALL cover reset mid-frame: rstn low after 2 data flits -> all outputs 0, no credit after release, next frame received correctly.
